// File: rtl/rx_block_sync_ctrl_if.sv
// Sync-header sample stream in, slip request plus lock/BER status out.
// The sample stream has no backpressure; every header is consumed in the cycle it is offered.
interface rx_block_sync_ctrl_if;
    logic       sh_valid_in;
    logic [1:0] sync_hdr;
    logic       clear_errblk;
    logic       rx_slip;
    logic       blk_lock;
    logic       hi_ber;
    logic [5:0] ber_cnt;

    modport master (
        output sh_valid_in, sync_hdr, clear_errblk,
        input  rx_slip, blk_lock, hi_ber, ber_cnt
    );

    modport slave (
        input  sh_valid_in, sync_hdr, clear_errblk,
        output rx_slip, blk_lock, hi_ber, ber_cnt
    );
endinterface

// File: rtl/rx_block_sync_ctrl.sv
// 64b/66b block lock FSM with bit-slip requests, 125 us BER monitor and errored-header count.
// Outputs are registered (sample at N visible at N+1); headers are never backpressured.
module rx_block_sync_ctrl #(
    parameter int LOCK_CNT    = 64,
    parameter int INVALID_MAX = 16,
    parameter int SLIP_WAIT   = 4,
    parameter int BER_WINDOW  = 19531,
    parameter int BER_LIMIT   = 16
) (
    input  logic               clk156,
    input  logic               rst156,
    rx_block_sync_ctrl_if.slave rx
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int INV_W  = $clog2(INVALID_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
    localparam int TMR_W  = $clog2(BER_WINDOW);
    localparam int WIN_W  = $clog2(BER_LIMIT + 1);

    typedef enum logic [1:0] {
        RESET_CNT,
        TEST_SH,
        SLIP,
        SLIP_HOLD
    } state_t;

    state_t              state, state_nxt;
    logic [SH_W-1:0]     sh_cnt, sh_cnt_nxt, sh_inc;
    logic [INV_W-1:0]    inv_cnt, inv_cnt_nxt, inv_inc;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                lock_q, lock_nxt;
    logic                slip_q;
    logic                hi_ber_q;
    logic [5:0]          ber_cnt_q;
    logic [TMR_W-1:0]    ber_tmr;
    logic [WIN_W-1:0]    win_cnt, win_inc;
    logic                hdr_bad, bad_sample, ber_wrap;

    // 2'b00 and 2'b11 carry no data/control transition and are never legal headers
    assign hdr_bad    = (rx.sync_hdr[1] == rx.sync_hdr[0]);
    assign bad_sample = rx.sh_valid_in && hdr_bad;
    assign sh_inc     = sh_cnt + SH_W'(1);
    assign inv_inc    = inv_cnt + INV_W'(hdr_bad);

    always_comb begin
        state_nxt    = state;
        sh_cnt_nxt   = sh_cnt;
        inv_cnt_nxt  = inv_cnt;
        wait_cnt_nxt = wait_cnt;
        lock_nxt     = lock_q;
        case (state)
            RESET_CNT: begin
                sh_cnt_nxt  = '0;
                inv_cnt_nxt = '0;
                state_nxt   = TEST_SH;
            end
            TEST_SH: begin
                if (rx.sh_valid_in) begin
                    sh_cnt_nxt  = sh_inc;
                    inv_cnt_nxt = inv_inc;
                    if (!lock_q) begin
                        if (hdr_bad) begin
                            state_nxt = SLIP;
                        end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                            lock_nxt  = 1'b1;
                            state_nxt = RESET_CNT;
                        end
                    end else if (inv_inc == INV_W'(INVALID_MAX)) begin
                        // losing lock outranks a window that completes on the same sample
                        lock_nxt  = 1'b0;
                        state_nxt = SLIP;
                    end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                        state_nxt = RESET_CNT;
                    end
                end
            end
            SLIP: begin
                wait_cnt_nxt = '0;
                state_nxt    = SLIP_HOLD;
            end
            SLIP_HOLD: begin
                if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_nxt = RESET_CNT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = RESET_CNT;
        endcase
    end

    always_ff @(posedge clk156 or posedge rst156) begin
        if (rst156) begin
            state    <= RESET_CNT;
            sh_cnt   <= '0;
            inv_cnt  <= '0;
            wait_cnt <= '0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sh_cnt   <= sh_cnt_nxt;
            inv_cnt  <= inv_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            lock_q   <= lock_nxt;
            slip_q   <= (state_nxt == SLIP);
        end
    end

    assign ber_wrap = (ber_tmr == TMR_W'(BER_WINDOW - 1));

    always_comb begin
        win_inc = win_cnt;
        if (bad_sample && (win_cnt != WIN_W'(BER_LIMIT))) begin
            win_inc = win_cnt + WIN_W'(1);
        end
    end

    // Window timing is anchored to the first locked cycle and frozen while unlocked
    always_ff @(posedge clk156 or posedge rst156) begin
        if (rst156) begin
            ber_tmr  <= '0;
            win_cnt  <= '0;
            hi_ber_q <= 1'b0;
        end else if (!lock_q) begin
            ber_tmr  <= '0;
            win_cnt  <= '0;
            hi_ber_q <= 1'b0;
        end else if (ber_wrap) begin
            ber_tmr  <= '0;
            win_cnt  <= WIN_W'(bad_sample);
            hi_ber_q <= (win_cnt == WIN_W'(BER_LIMIT));
        end else begin
            ber_tmr <= ber_tmr + TMR_W'(1);
            win_cnt <= win_inc;
            if (win_inc == WIN_W'(BER_LIMIT)) begin
                hi_ber_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk156 or posedge rst156) begin
        if (rst156) begin
            ber_cnt_q <= '0;
        end else if (rx.clear_errblk) begin
            ber_cnt_q <= '0;
        end else if (lock_q && bad_sample && (ber_cnt_q != 6'd63)) begin
            ber_cnt_q <= ber_cnt_q + 6'd1;
        end
    end

    assign rx.rx_slip  = slip_q;
    assign rx.blk_lock = lock_q;
    assign rx.hi_ber   = hi_ber_q;
    assign rx.ber_cnt  = ber_cnt_q;

endmodule

// File: tb/tb_rx_block_sync_ctrl.sv
// Directed scenarios plus random header streams, checked every cycle against a cycle-count model.
module tb_rx_block_sync_ctrl;
    localparam int LOCK_CNT    = 64;
    localparam int INVALID_MAX = 16;
    localparam int SLIP_WAIT   = 4;
    localparam int BER_WINDOW  = 19531;
    localparam int BER_LIMIT   = 16;

    logic clk156 = 1'b0;
    logic rst156 = 1'b0;
    always #5 clk156 = ~clk156;

    rx_block_sync_ctrl_if bus();

    rx_block_sync_ctrl #(
        .LOCK_CNT(LOCK_CNT), .INVALID_MAX(INVALID_MAX), .SLIP_WAIT(SLIP_WAIT),
        .BER_WINDOW(BER_WINDOW), .BER_LIMIT(BER_LIMIT)
    ) dut (
        .clk156(clk156),
        .rst156(rst156),
        .rx(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycle numbers since reset release instead of a state machine
    int cyc, test_from, m_cnt, m_inv, lock_cyc, win_bad, m_bercnt;
    bit m_lock, m_slip, m_hiber;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; test_from = 1; m_cnt = 0; m_inv = 0; lock_cyc = 0;
        win_bad = 0; m_bercnt = 0; m_lock = 0; m_slip = 0; m_hiber = 0;
    endtask

    task automatic model_step(input bit v, input bit bad, input bit clr);
        bit nl, ns, nh, s;
        int nb, pos;
        s = v && bad;
        nl = m_lock; ns = 0; nh = m_hiber; nb = m_bercnt;
        if (v && cyc >= test_from) begin
            m_cnt++;
            if (bad) m_inv++;
            if (!m_lock) begin
                if (bad) begin
                    ns = 1; test_from = cyc + SLIP_WAIT + 3; m_cnt = 0; m_inv = 0;
                end else if (m_cnt == LOCK_CNT) begin
                    nl = 1; test_from = cyc + 2; m_cnt = 0; m_inv = 0;
                end
            end else if (m_inv == INVALID_MAX) begin
                nl = 0; ns = 1; test_from = cyc + SLIP_WAIT + 3; m_cnt = 0; m_inv = 0;
            end else if (m_cnt == LOCK_CNT) begin
                test_from = cyc + 2; m_cnt = 0; m_inv = 0;
            end
        end
        if (m_lock) begin
            pos = (cyc - lock_cyc) % BER_WINDOW;
            if (s && nb < 63) nb++;
            if (pos == BER_WINDOW - 1) begin
                if (win_bad < BER_LIMIT) nh = 0;
                win_bad = s ? 1 : 0;
            end else begin
                if (s && win_bad < BER_LIMIT) win_bad++;
                if (win_bad == BER_LIMIT) nh = 1;
            end
        end else begin
            win_bad = 0; nh = 0;
        end
        if (clr) nb = 0;
        if (nl && !m_lock) lock_cyc = cyc + 1;
        m_lock = nl; m_slip = ns; m_hiber = nh; m_bercnt = nb;
        cyc++;
    endtask

    function automatic logic [1:0] rand_hdr(input bit bad);
        if (bad) return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic step(input bit v, input logic [1:0] h, input bit clr);
        bus.sh_valid_in  = v;
        bus.sync_hdr     = h;
        bus.clear_errblk = clr;
        @(posedge clk156);
        #1;
        model_step(v, h[1] == h[0], clr);
        chk("model_rx_slip", 16'(bus.rx_slip), 16'(m_slip));
        chk("model_blk_lock", 16'(bus.blk_lock), 16'(m_lock));
        chk("model_hi_ber", 16'(bus.hi_ber), 16'(m_hiber));
        chk("model_ber_cnt", 16'(bus.ber_cnt), 16'(m_bercnt));
    endtask

    task automatic async_reset();
        rst156 = 1'b1;
        #1;
        chk("rst_rx_slip", 16'(bus.rx_slip), 16'd0);
        chk("rst_blk_lock", 16'(bus.blk_lock), 16'd0);
        chk("rst_hi_ber", 16'(bus.hi_ber), 16'd0);
        chk("rst_ber_cnt", 16'(bus.ber_cnt), 16'd0);
        @(posedge clk156);
        #1;
        rst156 = 1'b0;
        model_reset();
    endtask

    // Caller must be positioned at a RESET_CNT cycle (right after a window closes)
    task automatic lock_window(input int nbad, input bit bad_last);
        bit flags [64];
        int n, p;
        foreach (flags[i]) flags[i] = 1'b0;
        n = 0;
        if (bad_last) begin flags[63] = 1'b1; n = 1; end
        while (n < nbad) begin
            p = $urandom_range(0, 62);
            if (!flags[p]) begin flags[p] = 1'b1; n++; end
        end
        step(1'b1, rand_hdr(1'b0), 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, rand_hdr(flags[i]), 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int o1, o2, o3, rate;
        bus.sh_valid_in = 1'b0; bus.sync_hdr = 2'b01; bus.clear_errblk = 1'b0;
        model_reset();
        #2;
        async_reset();

        // Lock after 64 valid samples; the cycle-0 sample lands in RESET_CNT and is dropped
        step(1'b1, rand_hdr(1'b0), 1'b0);
        repeat (63) step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t1_before_64th", 16'(bus.blk_lock), 16'd0);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t1_locked", 16'(bus.blk_lock), 16'd1);
        chk("t1_no_slip", 16'(bus.rx_slip), 16'd0);

        lock_window(15, 1'b0);
        chk("t3_15_invalid_hold", 16'(bus.blk_lock), 16'd1);
        lock_window(16, 1'b1);
        chk("t3_16th_on_64th_drop", 16'(bus.blk_lock), 16'd0);
        chk("t3_slip_on_drop", 16'(bus.rx_slip), 16'd1);

        // Slip, hold and RESET_CNT swallow six cycles even with invalid headers
        repeat (6) step(1'b1, rand_hdr(1'b1), 1'b0);
        chk("t2_hold_no_slip", 16'(bus.rx_slip), 16'd0);
        repeat (9) step(1'b1, rand_hdr(1'b0), 1'b0);
        step(1'b1, 2'b11, 1'b0);
        chk("t2_slip_pulse", 16'(bus.rx_slip), 16'd1);
        step(1'b1, rand_hdr(1'b1), 1'b0);
        chk("t2_slip_single", 16'(bus.rx_slip), 16'd0);
        repeat (5) step(1'b1, rand_hdr(1'b1), 1'b0);
        repeat (63) step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t2_count_restart", 16'(bus.blk_lock), 16'd0);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t2_relock", 16'(bus.blk_lock), 16'd1);

        step(1'b1, rand_hdr(1'b0), 1'b1);
        for (int i = 0; i < 70; i++) begin
            step(1'b1, rand_hdr(1'b1), 1'b0);
            repeat (5) step(1'b1, rand_hdr(1'b0), 1'b0);
        end
        chk("t5_ber_cnt_sat", 16'(bus.ber_cnt), 16'd63);
        chk("t4_hi_ber_set", 16'(bus.hi_ber), 16'd1);
        chk("t4_lock_kept", 16'(bus.blk_lock), 16'd1);

        while (((cyc - lock_cyc) % BER_WINDOW) != BER_WINDOW - 1)
            step($urandom_range(0, 3) != 0, rand_hdr(1'b0), 1'b0);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t4_wrap1_keeps_hi_ber", 16'(bus.hi_ber), 16'd1);

        o1 = $urandom_range(0, BER_WINDOW - 2);
        do o2 = $urandom_range(0, BER_WINDOW - 2); while (o2 == o1);
        do o3 = $urandom_range(0, BER_WINDOW - 2); while (o3 == o1 || o3 == o2);
        for (int i = 0; i < BER_WINDOW - 1; i++)
            step(1'b1, rand_hdr(i == o1 || i == o2 || i == o3), 1'b0);
        chk("t4_hi_ber_until_wrap", 16'(bus.hi_ber), 16'd1);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t4_hi_ber_clear_after_wrap", 16'(bus.hi_ber), 16'd0);

        step(1'b1, rand_hdr(1'b1), 1'b1);
        chk("t5_clear_wins", 16'(bus.ber_cnt), 16'd0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, rand_hdr(1'b1), 1'b0);
            repeat (5) step(1'b1, rand_hdr(1'b0), 1'b0);
        end
        chk("t6_hi_ber_before_rst", 16'(bus.hi_ber), 16'd1);
        async_reset();
        step(1'b1, rand_hdr(1'b0), 1'b0);
        repeat (63) step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t6_relock_not_early", 16'(bus.blk_lock), 16'd0);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        chk("t6_relock", 16'(bus.blk_lock), 16'd1);

        async_reset();
        step(1'b1, rand_hdr(1'b0), 1'b0);
        step(1'b1, rand_hdr(1'b1), 1'b0);
        chk("t6_slip_before_rst", 16'(bus.rx_slip), 16'd1);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        step(1'b1, rand_hdr(1'b0), 1'b0);
        async_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rand_hdr(1'b0), 1'b0);
            chk("t6_no_slip_after_rst", 16'(bus.rx_slip), 16'd0);
        end

        async_reset();
        for (int seg = 0; seg < 15; seg++) begin
            rate = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 60 : 5);
            repeat (200) step($urandom_range(0, 3) != 0,
                              rand_hdr(rate != 0 && $urandom_range(1, rate) == 1),
                              $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
